// File: rtl/native_mem_master.sv
// native_mem_master
//   Initiator for the native valid/ready memory bus. Commands are buffered in
//   a small FIFO and issued one at a time. Each request is held stable until
//   the responder pulses mem_ready. The read data is then returned on a
//   response port that supports backpressure.
//
//   Optional feature macro: NATIVE_MEM_MASTER_TIMEOUT_EN
//     When defined, a request with no mem_ready for TIMEOUT_CYCLES cycles is
//     aborted. The abort returns rsp_error=1 and rsp_rdata=0. When the macro
//     is undefined, REQ waits indefinitely and rsp_error is tied to 0.
//
//   Ports
//     clk, resetn        : clock (rising edge), synchronous active-low reset
//     cmd_valid/ready    : command handshake; cmd_ready = FIFO not full
//     cmd_addr/wdata     : 32-bit byte address / write data
//     cmd_wstrb          : byte enables; 0 means read
//     rsp_valid/ready    : response handshake
//     rsp_rdata          : data captured from mem_rdata
//     rsp_error          : request aborted by timeout
//     mem_valid/ready    : native bus request / one-cycle completion pulse
//     mem_addr/wdata     : request address / write data
//     mem_wstrb          : request byte enables
//     mem_rdata          : responder read data, valid with mem_ready
//     busy               : FIFO non-empty or a transaction in progress
module native_mem_master #(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int PW = AW + 1;

    if ((CMD_DEPTH < 2) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 2)) begin : g_bad_param
        $error("native_mem_master: CMD_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

    // Command FIFO storage (data only, no reset needed)
    logic [31:0] r_fifo_addr  [CMD_DEPTH];
    logic [31:0] r_fifo_wdata [CMD_DEPTH];
    logic [3:0]  r_fifo_wstrb [CMD_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;

    logic w_full, w_empty, w_push, w_pop;
    logic [31:0] w_head_addr, w_head_wdata;
    logic [3:0]  w_head_wstrb;

    state_t      r_state, w_state_nxt;
    logic        r_mem_valid, w_mem_valid_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [3:0]  r_mem_wstrb, w_mem_wstrb_nxt;
    logic        r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
`ifdef NATIVE_MEM_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic          r_rsp_error, w_rsp_error_nxt;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;
`endif

    // Pointers carry one extra wrap bit so full and empty can be told apart
    assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_push  = cmd_valid && !w_full;

    assign w_head_addr  = r_fifo_addr[r_rptr[AW-1:0]];
    assign w_head_wdata = r_fifo_wdata[r_rptr[AW-1:0]];
    assign w_head_wstrb = r_fifo_wstrb[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr[AW-1:0]]  <= cmd_addr;
            r_fifo_wdata[r_wptr[AW-1:0]] <= cmd_wdata;
            r_fifo_wstrb[r_wptr[AW-1:0]] <= cmd_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wstrb_nxt = r_mem_wstrb;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
`ifdef NATIVE_MEM_MASTER_TIMEOUT_EN
        w_rsp_error_nxt = r_rsp_error;
        w_tcnt_nxt      = r_tcnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_mem_addr_nxt  = w_head_addr;
                    w_mem_wdata_nxt = w_head_wdata;
                    w_mem_wstrb_nxt = w_head_wstrb;
                    w_mem_valid_nxt = 1'b1;
                    w_state_nxt     = S_REQ;
`ifdef NATIVE_MEM_MASTER_TIMEOUT_EN
                    w_tcnt_nxt      = '0;
`endif
                end
            end
            S_REQ: begin
                // mem_ready takes priority over a timeout on the same cycle
                if (mem_ready) begin
                    w_rsp_rdata_nxt = mem_rdata;
                    w_mem_valid_nxt = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_RSP;
`ifdef NATIVE_MEM_MASTER_TIMEOUT_EN
                    w_rsp_error_nxt = 1'b0;
                end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_rsp_rdata_nxt = '0;
                    w_rsp_error_nxt = 1'b1;
                    w_mem_valid_nxt = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_RSP;
                end else begin
                    w_tcnt_nxt      = r_tcnt + TW'(1);
`endif
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    if (!w_empty) begin
                        w_pop           = 1'b1;
                        w_mem_addr_nxt  = w_head_addr;
                        w_mem_wdata_nxt = w_head_wdata;
                        w_mem_wstrb_nxt = w_head_wstrb;
                        w_mem_valid_nxt = 1'b1;
                        w_state_nxt     = S_REQ;
`ifdef NATIVE_MEM_MASTER_TIMEOUT_EN
                        w_tcnt_nxt      = '0;
`endif
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef NATIVE_MEM_MASTER_TIMEOUT_EN
            r_rsp_error <= 1'b0;
            r_tcnt      <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wstrb <= w_mem_wstrb_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
`ifdef NATIVE_MEM_MASTER_TIMEOUT_EN
            r_rsp_error <= w_rsp_error_nxt;
            r_tcnt      <= w_tcnt_nxt;
`endif
        end
    end

    assign cmd_ready = !w_full;
    assign busy      = !w_empty || (r_state != S_IDLE);
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
`ifdef NATIVE_MEM_MASTER_TIMEOUT_EN
    assign rsp_error = r_rsp_error;
`else
    assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_native_mem_master.sv
// Directed testbench for native_mem_master (CMD_DEPTH=4, TIMEOUT_CYCLES=16).
// Includes a zero-wait native-bus responder model with a 256-word memory.
// Outputs are sampled on the falling edge and inputs change away from the
// rising edge.
module tb_native_mem_master;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Responder controls
    logic        hang = 1'b0;
    logic        late_ready = 1'b0;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    native_mem_master #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    assign mem_ready = r_ready | late_ready;
    assign mem_rdata = late_ready ? 32'hBAD0BAD0 : r_rdata;

    // Zero-wait responder: ready one cycle after it sees a new request.
    // Memory word i initialises to 0xA5A50000 | i.
    always @(posedge clk) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A50000 | i;
        end else if (mem_valid && !mem_ready && !hang) begin
            r_ready <= 1'b1;
            r_rdata <= mem[mem_addr[9:2]];
            if (mem_wstrb[0]) mem[mem_addr[9:2]][7:0]   <= mem_wdata[7:0];
            if (mem_wstrb[1]) mem[mem_addr[9:2]][15:8]  <= mem_wdata[15:8];
            if (mem_wstrb[2]) mem[mem_addr[9:2]][23:16] <= mem_wdata[23:16];
            if (mem_wstrb[3]) mem[mem_addr[9:2]][31:24] <= mem_wdata[31:24];
        end else begin
            r_ready <= 1'b0;
        end
    end

    // Offer one command; returns 1 time unit after the accepting edge
    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        @(negedge clk);
        cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL push_accept: cmd_ready never rose for addr %h", a);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    // Issue a command and wait (bounded) for its response; rsp_ready assumed 1
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd, output logic er, output logic got);
        got = 1'b0; rd = '0; er = 1'b0;
        push(a, d, s);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rd = rsp_rdata; er = rsp_error; got = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid: got %b expected 0", mem_valid); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp_error: got %b expected 0", rsp_error); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin failures++; $display("FAIL reset_mem_bus: got %h/%h/%h expected 0", mem_addr, mem_wdata, mem_wstrb); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
        resetn = 1'b1;
    endtask

    task automatic test_write;
        rsp_ready = 1'b1;
        push(32'h100, 32'hDEADBEEF, 4'hF);
        @(negedge clk); // after E0
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL wr_e0_mem_valid: got %b expected 0", mem_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_e0_busy: got %b expected 1", busy); end
        @(negedge clk); // after E1
        checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL wr_e1_mem_valid: got %b expected 1", mem_valid); end
        checks++; if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h100, 32'hDEADBEEF, 4'hF}) begin failures++; $display("FAIL wr_e1_bus: got %h/%h/%h expected 100/deadbeef/f", mem_addr, mem_wdata, mem_wstrb); end
        @(negedge clk); // after E2
        checks++; if ({mem_valid, mem_ready} !== 2'b11) begin failures++; $display("FAIL wr_e2_handshake: got valid=%b ready=%b expected 1/1", mem_valid, mem_ready); end
        checks++; if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h100, 32'hDEADBEEF, 4'hF}) begin failures++; $display("FAIL wr_e2_stable: got %h/%h/%h expected 100/deadbeef/f", mem_addr, mem_wdata, mem_wstrb); end
        @(negedge clk); // after E3
        checks++; if ({mem_valid, rsp_valid, rsp_error} !== 3'b010) begin failures++; $display("FAIL wr_e3_rsp: got mv=%b rv=%b err=%b expected 0/1/0", mem_valid, rsp_valid, rsp_error); end
        @(negedge clk); // after E4
        checks++; if ({rsp_valid, busy} !== 2'b00) begin failures++; $display("FAIL wr_e4_done: got rv=%b busy=%b expected 0/0", rsp_valid, busy); end
    endtask

    task automatic test_readback;
        logic [31:0] rd; logic er, got;
        run_cmd(32'h100, 32'h0, 4'h0, rd, er, got);
        checks++; if (!got || rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL readback_full: got=%b rdata %h err %b expected deadbeef/0", got, rd, er); end
        run_cmd(32'h100, 32'h00001234, 4'h3, rd, er, got);
        checks++; if (!got) begin failures++; $display("FAIL partial_write_rsp: no response, expected one"); end
        run_cmd(32'h100, 32'h0, 4'h0, rd, er, got);
        checks++; if (!got || rd !== 32'hDEAD1234) begin failures++; $display("FAIL readback_partial: got=%b rdata %h expected dead1234", got, rd); end
    endtask

    task automatic test_back_to_back;
        logic [6:0] mv, rv;
        mv = '0; rv = '0;
        rsp_ready = 1'b1;
        push(32'h200, 32'h0, 4'h0);
        push(32'h204, 32'h0, 4'h0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            mv = {mv[5:0], mem_valid};
            rv = {rv[5:0], rsp_valid};
        end
        checks++; if (mv !== 7'b1101100) begin failures++; $display("FAIL b2b_mem_valid: got %b expected 1101100", mv); end
        checks++; if (rv !== 7'b0010010) begin failures++; $display("FAIL b2b_rsp_valid: got %b expected 0010010", rv); end
    endtask

    task automatic test_fifo_full;
        logic [31:0] exp_d [5];
        int idx;
        exp_d[0] = 32'hA5A50080; exp_d[1] = 32'hA5A50081; exp_d[2] = 32'hA5A50082;
        exp_d[3] = 32'hA5A50083; exp_d[4] = 32'hA5A50084;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h200 + 32'(4 * i), 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_cmd_ready: got %b expected 0", cmd_ready); end
        checks++; if ({rsp_valid, busy} !== 2'b11) begin failures++; $display("FAIL full_state: got rv=%b busy=%b expected 1/1", rsp_valid, busy); end
        // Sixth command offered while full must be refused
        cmd_addr = 32'h214; cmd_wdata = '0; cmd_wstrb = 4'h0; cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        idx = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin
                if (idx < 5) begin
                    checks++;
                    if (rsp_rdata !== exp_d[idx]) begin failures++; $display("FAIL full_order_%0d: got %h expected %h", idx, rsp_rdata, exp_d[idx]); end
                end
                idx++;
            end
            @(negedge clk);
        end
        checks++; if (idx !== 5) begin failures++; $display("FAIL full_count: got %0d responses expected 5", idx); end
    endtask

    task automatic test_backpressure;
        int n; logic ok; int idx; logic [31:0] last;
        rsp_ready = 1'b0;
        push(32'h100, 32'h0, 4'h0);
        push(32'h204, 32'h0, 4'h0);
        n = 0;
        while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_arrive: got %b expected 1", rsp_valid); end
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD1234 || mem_valid !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        checks++; if (!ok) begin failures++; $display("FAIL bp_hold: got rv=%b rdata=%h mv=%b expected 1/dead1234/0", rsp_valid, rsp_rdata, mem_valid); end
        rsp_ready = 1'b1;
        idx = 0; last = '0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin idx++; last = rsp_rdata; end
            @(negedge clk);
        end
        checks++; if (idx !== 2 || last !== 32'hA5A50081) begin failures++; $display("FAIL bp_drain: got %0d rsps last %h expected 2/a5a50081", idx, last); end
    endtask

    task automatic test_timeout;
        logic [31:0] rd; logic er, got;
        int n;
        rsp_ready = 1'b1;
        hang = 1'b1;
        push(32'h300, 32'h0, 4'h0);
`ifdef NATIVE_MEM_MASTER_TIMEOUT_EN
        repeat (17) @(negedge clk); // after E16
        checks++; if ({mem_valid, rsp_valid} !== 2'b10) begin failures++; $display("FAIL to_before: got mv=%b rv=%b expected 1/0", mem_valid, rsp_valid); end
        @(negedge clk); // after E17
        checks++; if ({mem_valid, rsp_valid, rsp_error} !== 3'b011 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL to_abort: got mv=%b rv=%b err=%b rdata=%h expected 0/1/1/0", mem_valid, rsp_valid, rsp_error, rsp_rdata); end
        hang = 1'b0;
        run_cmd(32'h100, 32'h0, 4'h0, rd, er, got);
        checks++; if (!got || rd !== 32'hDEAD1234 || er !== 1'b0) begin failures++; $display("FAIL to_next: got=%b rdata %h err %b expected dead1234/0", got, rd, er); end
`else
        repeat (40) @(negedge clk);
        checks++; if ({mem_valid, rsp_valid, rsp_error} !== 3'b100 || mem_addr !== 32'h300) begin failures++; $display("FAIL wait_hold: got mv=%b rv=%b err=%b addr=%h expected 1/0/0/300", mem_valid, rsp_valid, rsp_error, mem_addr); end
        hang = 1'b0;
        got = 1'b0; rd = '0; er = 1'b1;
        for (n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; rd = rsp_rdata; er = rsp_error; end
        end
        checks++; if (!got || rd !== 32'hA5A500C0 || er !== 1'b0) begin failures++; $display("FAIL wait_done: got=%b rdata %h err %b expected a5a500c0/0", got, rd, er); end
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_req;
        logic quiet;
        rsp_ready = 1'b1;
        hang = 1'b1;
        push(32'h100, 32'h0, 4'h0);
        push(32'h104, 32'h0, 4'h0);
        push(32'h108, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if ({mem_valid, busy} !== 2'b11) begin failures++; $display("FAIL rst_pre: got mv=%b busy=%b expected 1/1", mem_valid, busy); end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        checks++; if ({mem_valid, busy, cmd_ready, rsp_valid} !== 4'b0010) begin failures++; $display("FAIL rst_post: got mv=%b busy=%b crdy=%b rv=%b expected 0/0/1/0", mem_valid, busy, cmd_ready, rsp_valid); end
        hang = 1'b0;
        late_ready = 1'b1;
        @(negedge clk);
        late_ready = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b0 || mem_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        checks++; if (!quiet) begin failures++; $display("FAIL rst_late_ready: got rv=%b mv=%b busy=%b expected 0/0/0", rsp_valid, mem_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_readback();
        test_back_to_back();
        test_fifo_full();
        test_backpressure();
        test_timeout();
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
